// File: rtl/enc_filter_ctrl.sv
// enc_filter_ctrl: quadrature encoder front end. Glitch-filters A/B/Z with one shared
//   run-time constant K, sequences K reloads (RUN -> LOAD -> SETTLE) so a reload never
//   produces counts, and decodes filtered A/B into a wrapping position with index capture.
// Latency: a clean pin change sampled at edge 1 reaches pos/dir/err/idx_valid at edge K+4.
// Backpressure: cfg_ready is high only in RUN; cfg_valid must be held until accepted.
// Ports: clk/rst (sync, active-high); chn_a/chn_b/chn_z raw pins; cfg_valid/cfg_const/
//   cfg_ready constant load handshake; err_clr clears err; pos/dir position and direction;
//   idx_pos/idx_valid index capture; err sticky illegal-transition flag.
// Optional: define ENC_INDEX_CLR_EN to zero pos on a filtered Z rising edge in RUN.
module enc_filter_ctrl #(
  parameter int CNT_W       = 16,
  parameter int FLT_W       = 8,
  parameter int FLT_DEFAULT = 5
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             chn_a,
  input  logic             chn_b,
  input  logic             chn_z,
  input  logic             cfg_valid,
  input  logic [FLT_W-1:0] cfg_const,
  output logic             cfg_ready,
  input  logic             err_clr,
  output logic [CNT_W-1:0] pos,
  output logic             dir,
  output logic [CNT_W-1:0] idx_pos,
  output logic             idx_valid,
  output logic             err
);

  typedef enum logic [1:0] {ST_RUN, ST_LOAD, ST_SETTLE} state_t;

  localparam logic [FLT_W:0] RUN_ONE = (FLT_W+1)'(1);

  // Channel bit order everywhere: [2]=A, [1]=B, [0]=Z.
  logic [2:0]            sync1_q, sync2_q;
  logic [2:0]            last_q;
  logic [2:0]            filt_q, filt_d;
  logic [2:0][FLT_W:0]   run_q, run_d;
  logic [FLT_W-1:0]      k_q;
  logic [FLT_W:0]        k_plus1;
  logic [FLT_W:0]        settle_q;
  state_t                state_q;
  logic                  cfg_ready_q;
  logic [1:0]            prev_ab_q;
  logic                  z_prev_q;
  logic [CNT_W-1:0]      pos_q, idx_pos_q;
  logic                  dir_q, idx_valid_q, err_q;

  logic [1:0]            g_prev, g_cur, delta;
  logic                  z_rise;

  // Run counters are one bit wider than K so they can hold K+1 even for K=2^FLT_W-1.
  assign k_plus1 = {1'b0, k_q} + RUN_ONE;

  always_comb begin
    run_d  = run_q;
    filt_d = filt_q;
    for (int i = 0; i < 3; i++) begin
      if (state_q == ST_LOAD) begin
        run_d[i]  = '0;
        filt_d[i] = filt_q[i];
      end else begin
        if (sync2_q[i] != last_q[i]) begin
          run_d[i] = RUN_ONE;
        end else if (run_q[i] < k_plus1) begin
          run_d[i] = run_q[i] + RUN_ONE;
        end else begin
          run_d[i] = run_q[i];
        end
        if (run_d[i] >= k_plus1) begin
          filt_d[i] = sync2_q[i];
        end
      end
    end
  end

  // Map the Gray pair to a 2-bit phase; the phase difference mod 4 gives the step:
  // 1 = up, 3 = down, 2 = both bits flipped (illegal), 0 = no movement.
  assign g_prev = {prev_ab_q[1], prev_ab_q[1] ^ prev_ab_q[0]};
  assign g_cur  = {filt_q[2], filt_q[2] ^ filt_q[1]};
  assign delta  = g_cur - g_prev;
  assign z_rise = filt_q[0] & ~z_prev_q;

  always_ff @(posedge clk) begin
    // Synchronizers are deliberately outside reset so pin levels present during reset
    // are already settled when the filters start counting.
    sync1_q <= {chn_a, chn_b, chn_z};
    sync2_q <= sync1_q;

    if (rst) begin
      state_q     <= ST_SETTLE;
      k_q         <= FLT_W'(FLT_DEFAULT);
      settle_q    <= '0;
      cfg_ready_q <= 1'b0;
      last_q      <= '0;
      filt_q      <= '0;
      run_q       <= '0;
      prev_ab_q   <= '0;
      z_prev_q    <= 1'b0;
      pos_q       <= '0;
      dir_q       <= 1'b0;
      idx_pos_q   <= '0;
      idx_valid_q <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      last_q      <= sync2_q;
      run_q       <= run_d;
      filt_q      <= filt_d;
      prev_ab_q   <= filt_q[2:1];
      z_prev_q    <= filt_q[0];
      idx_valid_q <= 1'b0;
      err_q       <= err_q & ~err_clr;

      case (state_q)
        ST_RUN: begin
          if (cfg_valid && cfg_ready_q) begin
            k_q         <= cfg_const;
            state_q     <= ST_LOAD;
            cfg_ready_q <= 1'b0;
          end
          if (z_rise) begin
            idx_pos_q   <= pos_q;
            idx_valid_q <= 1'b1;
          end
          case (delta)
            2'd1: begin
              pos_q <= pos_q + CNT_W'(1);
              dir_q <= 1'b1;
            end
            2'd3: begin
              pos_q <= pos_q - CNT_W'(1);
              dir_q <= 1'b0;
            end
            2'd2:    err_q <= 1'b1;
            default: ;
          endcase
`ifdef ENC_INDEX_CLR_EN
          // Index clear wins over a step landing in the same cycle.
          if (z_rise) begin
            pos_q <= '0;
          end
`endif
        end
        ST_LOAD: begin
          state_q  <= ST_SETTLE;
          settle_q <= '0;
        end
        ST_SETTLE: begin
          // K+2 cycles: K+1 to refill the cleared filters, one more so prev_ab sees them.
          if (settle_q == k_plus1) begin
            state_q     <= ST_RUN;
            cfg_ready_q <= 1'b1;
          end else begin
            settle_q <= settle_q + RUN_ONE;
          end
        end
        default: state_q <= ST_SETTLE;
      endcase
    end
  end

  assign cfg_ready = cfg_ready_q;
  assign pos       = pos_q;
  assign dir       = dir_q;
  assign idx_pos   = idx_pos_q;
  assign idx_valid = idx_valid_q;
  assign err       = err_q;

endmodule
